// File: rtl/debug_master_pkg.sv
// Shared types and constants for the serial-to-register debug bus master.
package debug_master_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADDR,
      S_DHI,
      S_DLO,
      S_BUS,
      S_GAP,
      S_RSP1,
      S_RSP2
   } state_t;

   localparam logic [7:0] ACK        = 8'h06;
   localparam logic [7:0] NAK        = 8'h15;
   localparam logic [7:0] CMD_WR_DEF = 8'h57;
   localparam logic [7:0] CMD_RD_DEF = 8'h52;

endpackage

// File: rtl/debug_bus_master_if.sv
// Byte stream in/out plus register bus of the debug master.
interface debug_bus_master_if;

   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_ready;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic [7:0]  dbg_a;
   logic [15:0] dbg_di;
   logic        dbg_we;
   logic        dbg_rd;
   logic [15:0] dbg_do;
   logic        dbg_ready;
   logic        busy;
   logic        timeout_err;

   modport master (
      input  rx_data, rx_valid, tx_ready, dbg_do, dbg_ready,
      output rx_ready, tx_data, tx_valid,
      output dbg_a, dbg_di, dbg_we, dbg_rd,
      output busy, timeout_err
   );

   modport slave (
      output rx_data, rx_valid, tx_ready, dbg_do, dbg_ready,
      input  rx_ready, tx_data, tx_valid,
      input  dbg_a, dbg_di, dbg_we, dbg_rd,
      input  busy, timeout_err
   );

endinterface

// File: rtl/debug_bus_master.sv
// Decodes W/R byte frames into register bus accesses and answers
// with ACK, NAK or two read-data bytes.
module debug_bus_master
   import debug_master_pkg::*;
#(
   parameter int         TIMEOUT_CYCLES = 1024,
   parameter logic [7:0] CMD_WR = CMD_WR_DEF,
   parameter logic [7:0] CMD_RD = CMD_RD_DEF
) (
   input logic clk,
   input logic rst_n,
   debug_bus_master_if.master bus
);

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

   state_t      state;
   logic        is_wr;
   logic        nak;
   logic [CW-1:0] cnt;
   logic [15:0] rdata;
   logic        rx_ready_q;
   logic        tx_valid_q;
   logic [7:0]  tx_data_q;
   logic [7:0]  dbg_a_q;
   logic [15:0] dbg_di_q;
   logic        we_q;
   logic        rd_q;
   logic        busy_q;
   logic        terr_q;
   logic        rx_take;

   assign rx_take = bus.rx_valid & rx_ready_q;

   assign bus.rx_ready    = rx_ready_q;
   assign bus.tx_valid    = tx_valid_q;
   assign bus.tx_data     = tx_data_q;
   assign bus.dbg_a       = dbg_a_q;
   assign bus.dbg_di      = dbg_di_q;
   assign bus.dbg_we      = we_q;
   assign bus.dbg_rd      = rd_q;
   assign bus.busy        = busy_q;
   assign bus.timeout_err = terr_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         is_wr      <= 1'b0;
         nak        <= 1'b0;
         cnt        <= '0;
         rdata      <= 16'h0000;
         rx_ready_q <= 1'b0;
         tx_valid_q <= 1'b0;
         tx_data_q  <= 8'h00;
         dbg_a_q    <= 8'h00;
         dbg_di_q   <= 16'h0000;
         we_q       <= 1'b0;
         rd_q       <= 1'b0;
         busy_q     <= 1'b0;
         terr_q     <= 1'b0;
      end else begin
         unique case (state)
            S_IDLE: begin
               rx_ready_q <= 1'b1;
               if (rx_take && (bus.rx_data == CMD_WR
                               || bus.rx_data == CMD_RD)) begin
                  is_wr  <= (bus.rx_data == CMD_WR);
                  busy_q <= 1'b1;
                  state  <= S_ADDR;
               end
            end
            S_ADDR: begin
               if (rx_take) begin
                  dbg_a_q <= bus.rx_data;
                  if (is_wr) begin
                     state <= S_DHI;
                  end else begin
                     rx_ready_q <= 1'b0;
                     rd_q       <= 1'b1;
                     cnt        <= '0;
                     state      <= S_BUS;
                  end
               end
            end
            S_DHI: begin
               if (rx_take) begin
                  dbg_di_q[15:8] <= bus.rx_data;
                  state          <= S_DLO;
               end
            end
            S_DLO: begin
               if (rx_take) begin
                  dbg_di_q[7:0] <= bus.rx_data;
                  rx_ready_q    <= 1'b0;
                  we_q          <= 1'b1;
                  cnt           <= '0;
                  state         <= S_BUS;
               end
            end
            S_BUS: begin
               // ready on the last counted cycle still wins over timeout
               if (bus.dbg_ready) begin
                  we_q  <= 1'b0;
                  rd_q  <= 1'b0;
                  nak   <= 1'b0;
                  state <= S_GAP;
                  if (!is_wr) rdata <= bus.dbg_do;
               end else if (cnt == CNT_LAST) begin
                  we_q   <= 1'b0;
                  rd_q   <= 1'b0;
                  nak    <= 1'b1;
                  terr_q <= 1'b1;
                  state  <= S_GAP;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            S_GAP: begin
               terr_q     <= 1'b0;
               tx_valid_q <= 1'b1;
               state      <= S_RSP1;
               if (nak)        tx_data_q <= NAK;
               else if (is_wr) tx_data_q <= ACK;
               else            tx_data_q <= rdata[15:8];
            end
            S_RSP1: begin
               if (bus.tx_ready) begin
                  if (!nak && !is_wr) begin
                     tx_data_q <= rdata[7:0];
                     state     <= S_RSP2;
                  end else begin
                     tx_valid_q <= 1'b0;
                     busy_q     <= 1'b0;
                     rx_ready_q <= 1'b1;
                     state      <= S_IDLE;
                  end
               end
            end
            S_RSP2: begin
               if (bus.tx_ready) begin
                  tx_valid_q <= 1'b0;
                  busy_q     <= 1'b0;
                  rx_ready_q <= 1'b1;
                  state      <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_debug_bus_master.sv
// Scoreboard bench: expected bus accesses and tx bytes are queued when
// frames are sent and popped as the master produces them.
module tb_debug_bus_master;
   import debug_master_pkg::*;

   typedef struct {
      logic        we;
      logic [7:0]  a;
      logic [15:0] di;
      int          len;
   } acc_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   debug_bus_master_if bus ();

   debug_bus_master dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;
   int lat = 0;
   int wc = 0;
   int stall = 0;
   int terr_n = 0;
   logic idle_rdy = 1'b0;

   acc_t       acc_q[$];
   logic [7:0] tx_q[$];

   assign bus.dbg_ready = (bus.dbg_we | bus.dbg_rd)
                          ? (lat >= 0 && wc == lat + 1) : idle_rdy;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t",
                  tag, obs, exp, $time);
      end
   endtask

   task automatic check_rst(input string tag);
      chk({tag, "_we"},   32'(bus.dbg_we), 32'd0);
      chk({tag, "_rd"},   32'(bus.dbg_rd), 32'd0);
      chk({tag, "_txv"},  32'(bus.tx_valid), 32'd0);
      chk({tag, "_txd"},  32'(bus.tx_data), 32'd0);
      chk({tag, "_rxr"},  32'(bus.rx_ready), 32'd0);
      chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
      chk({tag, "_terr"}, 32'(bus.timeout_err), 32'd0);
      chk({tag, "_a"},    32'(bus.dbg_a), 32'd0);
      chk({tag, "_di"},   32'(bus.dbg_di), 32'd0);
   endtask

   task automatic send_byte(input logic [7:0] b);
      int n = 0;
      bus.rx_data  = b;
      bus.rx_valid = 1'b1;
      do begin
         @(posedge clk);
         n++;
      end while (!bus.rx_ready && n < 3000);
      if (n >= 3000) chk("rx_accept", 32'(bus.rx_ready), 32'd1);
      #1;
      bus.rx_valid = 1'b0;
   endtask

   task automatic wait_done();
      int n = 0;
      while ((tx_q.size() != 0 || acc_q.size() != 0 || bus.busy)
             && n < 5000) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("done_busy", 32'(bus.busy), 32'd0);
      chk("done_txq", 32'(tx_q.size()), 32'd0);
   endtask

   task automatic exp_acc(input logic we, input logic [7:0] a,
                          input logic [15:0] di, input int len);
      acc_t e;
      e.we = we;
      e.a = a;
      e.di = di;
      e.len = len;
      acc_q.push_back(e);
   endtask

   // wait-state responder counter: in strobe cycle k, wc == k + 1
   initial begin : resp
      forever begin
         @(posedge clk);
         #1;
         wc = (bus.dbg_we || bus.dbg_rd) ? wc + 1 : 0;
      end
   end

   initial begin : tx_drv
      int hold = 0;
      bus.tx_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (bus.tx_valid && !bus.tx_ready) hold++;
         else hold = 0;
         bus.tx_ready = bus.tx_valid && hold > stall;
      end
   end

   initial begin : tx_mon
      logic pv = 1'b0;
      logic pr = 1'b0;
      logic [7:0] pd = 8'h00;
      forever begin
         @(posedge clk);
         if (!rst_n) begin
            pv = 1'b0;
         end else begin
            if (pv && !pr) begin
               chk("tx_hold_v", 32'(bus.tx_valid), 32'd1);
               chk("tx_hold_d", 32'(bus.tx_data), 32'(pd));
            end
            if (bus.tx_valid && bus.tx_ready) begin
               if (tx_q.size() == 0)
                  chk("tx_extra", 32'(tx_q.size()), 32'd1);
               else
                  chk("tx_byte", 32'(bus.tx_data), 32'(tx_q.pop_front()));
            end
            pv = bus.tx_valid;
            pr = bus.tx_ready;
            pd = bus.tx_data;
         end
         if (rst_n && bus.timeout_err) terr_n++;
      end
   end

   initial begin : bus_mon
      acc_t cur;
      int blen = 0;
      bit in_acc = 1'b0;
      cur.len = -1;
      forever begin
         @(posedge clk);
         if (!rst_n) begin
            in_acc = 1'b0;
            blen = 0;
         end else if (bus.dbg_we || bus.dbg_rd) begin
            if (!in_acc) begin
               if (acc_q.size() == 0) begin
                  chk("acc_extra", 32'(acc_q.size()), 32'd1);
                  cur.len = -1;
               end else begin
                  cur = acc_q.pop_front();
                  chk("acc_we", 32'(bus.dbg_we), 32'(cur.we));
                  chk("acc_both", 32'(bus.dbg_we & bus.dbg_rd), 32'd0);
                  chk("acc_a", 32'(bus.dbg_a), 32'(cur.a));
                  if (cur.we) chk("acc_di", 32'(bus.dbg_di), 32'(cur.di));
               end
            end
            in_acc = 1'b1;
            blen++;
         end else if (in_acc) begin
            if (cur.len >= 0) chk("strobe_len", 32'(blen), 32'(cur.len));
            chk("gap_txv", 32'(bus.tx_valid), 32'd0);
            in_acc = 1'b0;
            blen = 0;
         end
      end
   end

   initial begin : stim
      int t0;
      int n;
      bus.rx_data  = 8'h00;
      bus.rx_valid = 1'b0;
      bus.dbg_do   = 16'h0000;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_rst("rst");
      rst_n = 1'b1;

      // write, zero wait states
      lat = 0;
      exp_acc(1'b1, 8'h1B, 16'h1234, 1);
      tx_q.push_back(ACK);
      send_byte(8'h57); send_byte(8'h1B);
      send_byte(8'h12); send_byte(8'h34);
      wait_done();

      // read, three wait states
      lat = 3;
      bus.dbg_do = 16'hBEEF;
      exp_acc(1'b0, 8'h20, 16'h0000, 4);
      tx_q.push_back(8'hBE); tx_q.push_back(8'hEF);
      send_byte(8'h52); send_byte(8'h20);
      wait_done();

      // timeout
      lat = -1;
      t0 = terr_n;
      exp_acc(1'b0, 8'h05, 16'h0000, 1024);
      tx_q.push_back(NAK);
      send_byte(8'h52); send_byte(8'h05);
      wait_done();
      chk("terr_pulse", 32'(terr_n - t0), 32'd1);

      // ready on the last counted cycle
      lat = 1023;
      bus.dbg_do = 16'h1357;
      t0 = terr_n;
      exp_acc(1'b0, 8'h05, 16'h0000, 1024);
      tx_q.push_back(8'h13); tx_q.push_back(8'h57);
      send_byte(8'h52); send_byte(8'h05);
      wait_done();
      chk("terr_none", 32'(terr_n - t0), 32'd0);

      // garbage byte then read with tx backpressure
      lat = 1;
      stall = 5;
      bus.dbg_do = 16'h00A5;
      exp_acc(1'b0, 8'h10, 16'h0000, 2);
      tx_q.push_back(8'h00); tx_q.push_back(8'hA5);
      send_byte(8'h41); send_byte(8'h52); send_byte(8'h10);
      wait_done();
      stall = 0;

      // dbg_ready high outside BUS must not matter
      idle_rdy = 1'b1;
      lat = 2;
      exp_acc(1'b1, 8'h7F, 16'hABCD, 3);
      tx_q.push_back(ACK);
      send_byte(8'h57); send_byte(8'h7F);
      send_byte(8'hAB); send_byte(8'hCD);
      wait_done();
      idle_rdy = 1'b0;
      chk("hold_a", 32'(bus.dbg_a), 32'h7F);
      chk("hold_di", 32'(bus.dbg_di), 32'hABCD);

      // back-to-back frames stall on rx backpressure
      lat = 0;
      stall = 2;
      exp_acc(1'b1, 8'h01, 16'h0102, 1);
      exp_acc(1'b0, 8'h02, 16'h0000, 1);
      bus.dbg_do = 16'hC0DE;
      tx_q.push_back(ACK);
      tx_q.push_back(8'hC0); tx_q.push_back(8'hDE);
      send_byte(8'h57); send_byte(8'h01);
      send_byte(8'h01); send_byte(8'h02);
      send_byte(8'h52); send_byte(8'h02);
      wait_done();
      stall = 0;

      // reset during a write strobe
      lat = -1;
      exp_acc(1'b1, 8'h33, 16'h4455, -1);
      send_byte(8'h57); send_byte(8'h33);
      send_byte(8'h44); send_byte(8'h55);
      n = 0;
      while (!bus.dbg_we && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("we_seen", 32'(bus.dbg_we), 32'd1);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      check_rst("midrst");
      rst_n = 1'b1;
      lat = 0;
      exp_acc(1'b1, 8'h44, 16'h9876, 1);
      tx_q.push_back(ACK);
      send_byte(8'h57); send_byte(8'h44);
      send_byte(8'h98); send_byte(8'h76);
      wait_done();

      repeat (5) @(posedge clk);
      chk("acc_q_empty", 32'(acc_q.size()), 32'd0);
      chk("tx_q_empty", 32'(tx_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/debug_bus_master.md
DEBUG_BUS_MASTER -- requirements
Module: debug_bus_master

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1024, max cycles a bus strobe waits for dbg_ready.
REQ-002 SHALL have parameter CMD_WR, default 8'h57 ('W'), write command byte; CMD_RD, default 8'h52 ('R'), read command byte.
REQ-003 clk  input  1  system clock, all logic on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 rx_data  input  8  received byte; rx_valid  input  1  byte present; rx_ready  output  1  byte accepted when rx_valid&rx_ready.
REQ-006 tx_data  output  8  response byte; tx_valid  output  1  byte present; tx_ready  input  1  byte taken when tx_valid&tx_ready.
REQ-007 dbg_a  output  8  register address; dbg_di  output  16  write data; dbg_we  output  1  write strobe; dbg_rd  output  1  read strobe.
REQ-008 dbg_do  input  16  read data (valid while dbg_ready high); dbg_ready  input  1  access complete.
REQ-009 busy  output  1  high in any state except IDLE; timeout_err  output  1  one-cycle pulse on timeout.

Function
REQ-010 SHALL implement states IDLE, ADDR, DHI, DLO, BUS, GAP, RSP1, RSP2.
REQ-011 rx_ready SHALL be high only in IDLE, ADDR, DHI, DLO; low in all other states.
REQ-012 IDLE: accepted CMD_WR or CMD_RD -> latch op, go ADDR; any other byte consumed and dropped, stay IDLE.
REQ-013 ADDR: accepted byte -> dbg_a; write -> DHI, read -> BUS.
REQ-014 DHI: accepted byte -> dbg_di[15:8], go DLO; DLO: accepted byte -> dbg_di[7:0], go BUS.
REQ-015 BUS: dbg_we (write) or dbg_rd (read) SHALL be high every cycle in BUS, starting the cycle after the last frame byte is accepted; never both.
REQ-016 dbg_a and dbg_di SHALL hold stable from BUS entry until next frame's ADDR/DHI/DLO byte.
REQ-017 In BUS, the first cycle dbg_ready=1 completes the access; read captures dbg_do that cycle; strobe deasserts next cycle; go GAP.
REQ-018 Strobe SHALL be high for exactly N+1 cycles when dbg_ready rises N cycles after BUS entry (N=0 -> 1 cycle).
REQ-019 Timeout counter SHALL clear on BUS entry, increment each BUS cycle; dbg_ready=0 with count = TIMEOUT_CYCLES-1 -> timeout: strobe deasserts, timeout_err pulses, go GAP with NAK flagged.
REQ-020 dbg_ready arriving on the final counted cycle SHALL count as success, not timeout.
REQ-021 GAP: one cycle, all strobes low, guaranteeing >=1 idle cycle between consecutive bus accesses; then RSP1.
REQ-022 RSP1: tx_valid high; tx_data = 8'h15 (NAK) on timeout, 8'h06 (ACK) on write success, read_data[15:8] on read success.
REQ-023 RSP1 on tx_ready: read success -> RSP2, otherwise -> IDLE; RSP2: tx_data = read_data[7:0], on tx_ready -> IDLE.
REQ-024 tx_data SHALL remain stable while tx_valid=1 and tx_ready=0; tx_valid SHALL not drop before handshake.
REQ-025 rx bytes arriving while rx_ready=0 SHALL be left unconsumed (backpressure), never dropped.
REQ-026 dbg_ready high outside BUS SHALL be ignored.

Reset
REQ-027 On rst_n=0 at a clock edge: state IDLE; dbg_a=8'h00, dbg_di=16'h0000, dbg_we=0, dbg_rd=0, tx_valid=0, tx_data=8'h00, rx_ready=0 during reset, busy=0, timeout_err=0, counter 0, read_data 0.
REQ-028 Reset during BUS SHALL drop strobe on the next edge with no response byte emitted.

Structure
REQ-029 Shared package debug_master_pkg SHALL hold state enum, ACK 8'h06, NAK 8'h15, default command codes.
REQ-030 Single module, no sub-module; counter width $clog2(TIMEOUT_CYCLES+1).

Verification
REQ-031 Write: rx 57,1B,12,34; dbg_ready=1 combinational -> dbg_we high 1 cycle, dbg_a=1B, dbg_di=1234, tx 06.
REQ-032 Read wait-state: rx 52,20; dbg_ready high 3 cycles after BUS entry with dbg_do=BEEF -> dbg_rd high 4 cycles, tx BE then EF, GAP cycle observed.
REQ-033 Timeout: rx 52,05, dbg_ready held 0 -> dbg_rd high exactly 1024 cycles, timeout_err one pulse, tx 15; ready on cycle 1024 -> data returned, no pulse.
REQ-034 Garbage/backpressure: rx 41 then 52,10 with dbg_do=00A5; tx_ready low 5 cycles -> 41 dropped, tx_data holds 00 then A5 stable until accepted.
REQ-035 Reset mid-BUS: assert rst_n=0 during dbg_we -> next edge all outputs at reset values, no tx byte; new frame after release completes normally.
